// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and the execute stage behind it.
// Holds the instruction/operand types plus the execute-stage result and FSM state types.
package instr_register_pkg;

  localparam int OP_W   = 32;
  localparam int RES_W  = 64;
  localparam int ADDR_W = 5;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [OP_W-1:0] operand_t;
  typedef logic [ADDR_W-1:0]      address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef logic signed [RES_W-1:0] result_t;

  // State names are prefixed because DIV is already taken by opcode_t.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_WAIT_OUT
  } exec_state_t;

  function automatic result_t sext(input operand_t v);
    return result_t'(v);
  endfunction

endpackage

// File: rtl/exec_divider.sv
// Signed restoring divider: one quotient bit per clock, W clocks after start.
// Divides magnitudes, then applies signs (quotient toward zero, remainder follows dividend).
module exec_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvsr;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  // Magnitudes never exceed 2^(W-1), so W+1 bits hold the trial subtraction with its sign.
  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvsr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      quo   <= dividend[W-1] ? -dividend : dividend;
      dvsr  <= divisor[W-1] ? -divisor : divisor;
      cnt   <= CW'(W);
      neg_q <= dividend[W-1] ^ divisor[W-1];
      neg_r <= dividend[W-1];
      done  <= 1'b0;
    end else if (cnt != '0) begin
      if (!diff[W]) begin
        rem <= diff[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= shifted[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) done <= 1'b1;
    end
  end

  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage: single-cycle ALU ops, iterative DIV/MOD, one-entry registered output.
// Optional overflow flag port out_ovf is built only when EXEC_OVF_FLAG_EN is defined.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH  = 32,
  parameter int RES_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  instruction_t                in_instr,
  input  address_t                    in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [RES_WIDTH-1:0] out_result,
  output opcode_t                     out_opcode,
  output address_t                    out_tag,
  output logic                        out_div_zero,
`ifdef EXEC_OVF_FLAG_EN
  output logic                        out_ovf,
`endif
  output logic                        busy,
  output exec_state_t                 dbg_state
);

  localparam int CNT_W = $clog2(OP_WIDTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the output register holds all out_* while stalled.

  exec_state_t      state;
  logic [CNT_W-1:0] div_cnt;
  opcode_t          lat_opc;
  address_t         lat_tag;

  logic          free;
  logic          accept;
  logic          is_divop;
  logic          start_div;
  result_t       a_ext;
  result_t       b_ext;
  result_t       fast_result;
  result_t       div_result;
  logic [OP_WIDTH-1:0] div_quo;
  logic [OP_WIDTH-1:0] div_rem;
  logic          div_done;

  assign free      = !out_valid || out_ready;
  assign in_ready  = (state == ST_IDLE) && free;
  assign accept    = in_valid && in_ready;
  assign is_divop  = (in_instr.opc == DIV) || (in_instr.opc == MOD);
  assign start_div = accept && is_divop && (in_instr.op_b != '0);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // DIV/MOD with a zero divisor take this path and yield 0; unknown opcodes also yield 0.
  always_comb begin
    a_ext       = sext(in_instr.op_a);
    b_ext       = sext(in_instr.op_b);
    fast_result = '0;
    case (in_instr.opc)
      PASSA:   fast_result = a_ext;
      PASSB:   fast_result = b_ext;
      ADD:     fast_result = a_ext + b_ext;
      SUB:     fast_result = a_ext - b_ext;
      MULT:    fast_result = a_ext * b_ext;
      default: fast_result = '0;
    endcase
  end

`ifdef EXEC_OVF_FLAG_EN
  logic     fast_ovf;
  logic     lat_ovf;
  operand_t sum_w;
  operand_t dif_w;

  always_comb begin
    sum_w    = in_instr.op_a + in_instr.op_b;
    dif_w    = in_instr.op_a - in_instr.op_b;
    fast_ovf = 1'b0;
    case (in_instr.opc)
      ADD: fast_ovf = (in_instr.op_a[OP_WIDTH-1] == in_instr.op_b[OP_WIDTH-1]) &&
                      (sum_w[OP_WIDTH-1] != in_instr.op_a[OP_WIDTH-1]);
      SUB: fast_ovf = (in_instr.op_a[OP_WIDTH-1] != in_instr.op_b[OP_WIDTH-1]) &&
                      (dif_w[OP_WIDTH-1] != in_instr.op_a[OP_WIDTH-1]);
      default: fast_ovf = 1'b0;
    endcase
  end
`endif

  exec_divider #(.W(OP_WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (start_div),
    .dividend  (in_instr.op_a),
    .divisor   (in_instr.op_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // The divider keeps its result until the next start, which also covers WAIT_OUT.
  assign div_result = (lat_opc == MOD) ? sext(div_rem) : sext(div_quo);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      lat_opc      <= ZERO;
      lat_tag      <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_opcode   <= ZERO;
      out_tag      <= '0;
      out_div_zero <= 1'b0;
`ifdef EXEC_OVF_FLAG_EN
      out_ovf      <= 1'b0;
      lat_ovf      <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_div) begin
            state   <= ST_DIV;
            div_cnt <= CNT_W'(OP_WIDTH);
            lat_opc <= in_instr.opc;
            lat_tag <= in_tag;
`ifdef EXEC_OVF_FLAG_EN
            lat_ovf <= (in_instr.opc == DIV) &&
                       (in_instr.op_a == {1'b1, {(OP_WIDTH-1){1'b0}}}) &&
                       (in_instr.op_b == '1);
`endif
          end else if (accept) begin
            out_valid    <= 1'b1;
            out_result   <= fast_result;
            out_opcode   <= in_instr.opc;
            out_tag      <= in_tag;
            out_div_zero <= is_divop;
`ifdef EXEC_OVF_FLAG_EN
            out_ovf      <= fast_ovf;
`endif
          end
        end
        ST_DIV: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - CNT_W'(1);
          end else if (div_done) begin
            if (free) begin
              state        <= ST_IDLE;
              out_valid    <= 1'b1;
              out_result   <= div_result;
              out_opcode   <= lat_opc;
              out_tag      <= lat_tag;
              out_div_zero <= 1'b0;
`ifdef EXEC_OVF_FLAG_EN
              out_ovf      <= lat_ovf;
`endif
            end else begin
              state <= ST_WAIT_OUT;
            end
          end
        end
        ST_WAIT_OUT: begin
          if (free) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b1;
            out_result   <= div_result;
            out_opcode   <= lat_opc;
            out_tag      <= lat_tag;
            out_div_zero <= 1'b0;
`ifdef EXEC_OVF_FLAG_EN
            out_ovf      <= lat_ovf;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed corner cases then randomized traffic, scoreboarded
// against an arithmetic reference model. Define EXEC_OVF_FLAG_EN to include out_ovf.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  localparam int EXP_W = RES_W + 4 + ADDR_W + 2;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  instruction_t in_instr;
  address_t     in_tag;
  logic         out_valid;
  logic         out_ready;
  logic signed [RES_W-1:0] out_result;
  opcode_t      out_opcode;
  address_t     out_tag;
  logic         out_div_zero;
  logic         busy;
  exec_state_t  dbg_state;
  logic         act_ovf;

`ifdef EXEC_OVF_FLAG_EN
  logic out_ovf;
  assign act_ovf = out_ovf;
`else
  assign act_ovf = 1'b0;
`endif

  instr_exec_unit dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_opcode   (out_opcode),
    .out_tag      (out_tag),
    .out_div_zero (out_div_zero),
`ifdef EXEC_OVF_FLAG_EN
    .out_ovf      (out_ovf),
`endif
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit rand_rdy = 1'b0;
  bit rand_gap = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EXP_W-1:0] model(input instruction_t ins, input address_t tag);
    longint a = ins.op_a;
    longint b = ins.op_b;
    longint r = 0;
    bit dz = 1'b0;
    bit ov = 1'b0;
    case (ins.opc)
      ZERO:  r = 0;
      PASSA: r = a;
      PASSB: r = b;
      ADD:   begin r = a + b; ov = (r > MAXI) || (r < MINI); end
      SUB:   begin r = a - b; ov = (r > MAXI) || (r < MINI); end
      MULT:  r = a * b;
      DIV: begin
        if (b == 0) dz = 1'b1;
        else if (a == MINI && b == -1) begin r = MINI; ov = 1'b1; end
        else r = a / b;
      end
      MOD: begin
        if (b == 0) dz = 1'b1;
        else if (a == MINI && b == -1) r = 0;
        else r = a % b;
      end
      default: r = 0;
    endcase
`ifndef EXEC_OVF_FLAG_EN
    ov = 1'b0;
`endif
    return {ov, dz, ins.opc, tag, r};
  endfunction

  function automatic logic [EXP_W-1:0] actual();
    return {act_ovf, out_div_zero, out_opcode, out_tag, out_result};
  endfunction

  // ---------------- drivers ----------------
  // Called just after a falling edge; returns at the falling edge after the accepting edge.
  task automatic issue(input opcode_t opc, input logic [31:0] a, input logic [31:0] b,
                       input address_t tag);
    instruction_t ins;
    int w;
    ins.opc  = opc;
    ins.op_a = a;
    ins.op_b = b;
    in_instr = ins;
    in_tag   = tag;
    in_valid = 1'b1;
    #1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready 0 after %0d clks, required 1", w);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(ins, tag));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hffff_ffff;
      2:       return 32'h0;
      3:       return 32'h7fff_ffff;
      4:       return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom();
    endcase
  endfunction

  function automatic opcode_t rnd_opc();
    int v = $urandom_range(0, 11);
    if (v < 8) return opcode_t'(4'(v));
    if (v < 10) return opcode_t'(4'(v + $urandom_range(0, 6)));
    return (v == 10) ? ADD : SUB;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [EXP_W-1:0] held;
  bit hold_v = 1'b0;

  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("hold_stable", {out_valid, actual()}, {1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: actual %0h required none", actual());
          end else begin
            e = exp_q.pop_front();
            check("result", actual(), e);
          end
        end
        hold_v = out_valid && !out_ready;
        held   = actual();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int rdy_hi;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_opcode", out_opcode, ZERO);
    check("rst_out_tag", out_tag, 0);
    check("rst_div_zero", out_div_zero, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef EXEC_OVF_FLAG_EN
    check("rst_ovf", out_ovf, 0);
`endif
    @(negedge clk);

    // single-cycle latency
    issue(ADD, 32'd7, -32'sd15, 5'd3);
    #1 check("add_latency", out_valid, 1);
    check("add_value", out_result, -64'sd8);
    @(negedge clk);

    // back-to-back
    issue(MULT, -32'sd65536, 32'sd65536, 5'd4);
    issue(PASSB, 32'd1, 32'd9, 5'd5);
    issue(PASSA, 32'h8000_0000, 32'd0, 5'd6);
    issue(SUB, 32'h8000_0000, 32'd1, 5'd7);
    issue(ADD, 32'h7fff_ffff, 32'd1, 5'd8);
    issue(opcode_t'(4'd12), 32'd5, 32'd6, 5'd9);
    @(negedge clk);

    // iterative divide latency and in_ready low throughout
    issue(DIV, -32'sd17, 32'sd5, 5'd10);
    #1 check("div_busy", busy, 1);
    check("div_state", dbg_state, ST_DIV);
    n = 0;
    rdy_hi = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) rdy_hi++;
      @(negedge clk); #1;
      n++;
    end
    check("div_latency", n, 33);
    check("div_in_ready_low", rdy_hi, 0);
    @(negedge clk);
    issue(MOD, -32'sd17, 32'sd5, 5'd11);
    issue(DIV, 32'h8000_0000, 32'hffff_ffff, 5'd12);
    issue(MOD, 32'h8000_0000, 32'hffff_ffff, 5'd13);

    // divide by zero is single-cycle, then stall the output
    issue(DIV, 32'd99, 32'd0, 5'd14);
    out_ready = 1'b0;
    #1 check("div0_latency", out_valid, 1);
    check("div0_flag", out_div_zero, 1);
    repeat (5) begin
      @(negedge clk); #1;
      check("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);

    // divide with the consumer stalling around its completion
    issue(DIV, 32'd1000, -32'sd7, 5'd15);
    repeat (30) @(negedge clk);
    out_ready = 1'b0;
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // reset aborts a division in flight
    issue(DIV, 32'd123456, 32'd77, 5'd16);
    repeat (10) @(negedge clk);
    #1 check("pre_abort_busy", busy, 1);
    reset = 1'b1;
    #1 check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 250; i++) begin
      issue(rnd_opc(), rnd_op(), rnd_op(), address_t'($urandom()));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
